// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM states, error codes and
// common keyboard command bytes.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam logic [1:0] PS2_ERR_NONE    = 2'b00;
  localparam logic [1:0] PS2_ERR_NACK    = 2'b01;
  localparam logic [1:0] PS2_ERR_TIMEOUT = 2'b10;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: 2-flop synchronizer, FILTER_LEN-sample debounce and a one-cycle
// pulse on each filtered 1->0 transition. Shared with the keyboard receive path.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          s0;
  logic          s1;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronized samples that disagree with level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0    <= 1'b1;
      s1    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      s0   <= pin;
      s1   <= s0;
      fall <= 1'b0;
      if (s1 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= s1;
        cnt   <= '0;
        fall  <= ~s1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain oe outputs, odd parity, ACK check).
// Define PS2_TX_RETRY_EN to re-send the byte once after the first NACK or timeout.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  // tx_data is taken on the cycle tx_valid && tx_ready; tx_valid while busy is dropped.
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [7:0]       data_q;
  logic             parity_q;
  logic [3:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       frame;
  logic             c_level;
  logic             c_fall;
  logic             d_level;
  logic             unused_d_fall;
  logic             fail;
  logic [1:0]       fail_code;
`ifdef PS2_TX_RETRY_EN
  logic             retry;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_c_filter (
    .clk   (clk),
    .rst   (rst),
    .pin   (ps2c_in),
    .level (c_level),
    .fall  (c_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_d_filter (
    .clk   (clk),
    .rst   (rst),
    .pin   (ps2d_in),
    .level (d_level),
    .fall  (unused_d_fall)
  );

  // Stop bit is a 1, so presenting idx 9 releases the data line.
  assign frame = {1'b1, parity_q, data_q};

  // A clk_fall restarts the timeout window, so it never coincides with a timeout.
  always_comb begin
    fail      = 1'b0;
    fail_code = PS2_ERR_NONE;
    case (state)
      SHIFT: begin
        if (!c_fall && cnt >= TO_LAST) begin
          fail      = 1'b1;
          fail_code = PS2_ERR_TIMEOUT;
        end
      end
      ACK: begin
        if (c_fall && d_level) begin
          fail      = 1'b1;
          fail_code = PS2_ERR_NACK;
        end else if (!c_fall && cnt >= TO_LAST) begin
          fail      = 1'b1;
          fail_code = PS2_ERR_TIMEOUT;
        end
      end
      WAIT_IDLE: begin
        if (!(c_level && d_level) && !c_fall && cnt >= TO_LAST) begin
          fail      = 1'b1;
          fail_code = PS2_ERR_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ps2c_oe  <= 1'b0;
      ps2d_oe  <= 1'b0;
      busy     <= 1'b0;
      tx_ready <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= PS2_ERR_NONE;
      data_q   <= '0;
      parity_q <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
`ifdef PS2_TX_RETRY_EN
      retry    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (fail) begin
        ps2c_oe <= 1'b0;
        ps2d_oe <= 1'b0;
        cnt     <= '0;
`ifdef PS2_TX_RETRY_EN
        if (!retry) begin
          retry <= 1'b1;
          state <= INHIBIT;
        end else begin
          err      <= 1'b1;
          err_code <= fail_code;
          state    <= IDLE;
          busy     <= 1'b0;
          tx_ready <= 1'b1;
        end
`else
        err      <= 1'b1;
        err_code <= fail_code;
        state    <= IDLE;
        busy     <= 1'b0;
        tx_ready <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (tx_valid && tx_ready) begin
              data_q   <= tx_data;
              parity_q <= ~^tx_data;
              err_code <= PS2_ERR_NONE;
              state    <= INHIBIT;
              ps2c_oe  <= 1'b1;
              cnt      <= '0;
              busy     <= 1'b1;
              tx_ready <= 1'b0;
`ifdef PS2_TX_RETRY_EN
              retry    <= 1'b0;
`endif
            end else begin
              busy     <= 1'b0;
              tx_ready <= 1'b1;
            end
          end
          INHIBIT: begin
            ps2c_oe <= 1'b1;
            if (cnt >= INH_LAST) begin
              state   <= REQ;
              ps2d_oe <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          REQ: begin
            state   <= SHIFT;
            ps2c_oe <= 1'b0;
            idx     <= '0;
            cnt     <= '0;
          end
          SHIFT: begin
            if (c_fall) begin
              ps2d_oe <= ~frame[idx];
              idx     <= idx + 1'b1;
              cnt     <= '0;
              if (idx == 4'd9) state <= ACK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ACK: begin
            if (c_fall) begin
              state <= WAIT_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_IDLE: begin
            if (c_level && d_level) begin
              done     <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
            end else if (c_fall) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
